// File: rtl/mul_operand_sequencer_pkg.sv
// Shared definitions for the multiplier operand sequencer: FSM state encoding
// and the default data width used by the RTL and the bench.
package mul_operand_sequencer_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    LOAD_A = 3'd2,
    LOAD_B = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/mul_operand_sequencer_if.sv
// Operand/result streams plus the multiplier-side bus for the sequencer.
// slave is the sequencer's view; master is the surrounding environment's view.
interface mul_operand_sequencer_if
  import mul_operand_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_product;
  logic             out_timeout;
  logic             mul_start;
  logic [WIDTH-1:0] mul_data;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, mul_done, mul_product,
    output in_ready, out_valid, out_product, out_timeout, mul_start, mul_data, busy
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, mul_done, mul_product,
    input  in_ready, out_valid, out_product, out_timeout, mul_start, mul_data, busy
  );

endinterface

// File: rtl/mul_operand_sequencer_timeout.sv
// Saturating WAIT-state timer: clears on entry, counts while enabled and
// flags the terminal count combinationally for the sequencer FSM.
module mul_timeout_counter #(
  parameter int CNT_W    = 17,
  parameter int TERMINAL = 65539
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TERMINAL);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/mul_operand_sequencer.sv
// Feeds operand pairs to the repeated-addition multiplier (A then B on a
// shared bus), waits for done or timeout, and returns the product downstream.
//
//   state  | meaning
//   IDLE   | ready for a new operand pair
//   START  | start pulse, A on the bus
//   LOAD_A | controller loads A
//   LOAD_B | controller loads B and clears P
//   WAIT   | B held, waiting for done or timeout
//   DONE   | result presented until accepted
module mul_operand_sequencer
  import mul_operand_sequencer_pkg::*;
#(
  parameter int WIDTH          = WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 65540,
  parameter int CNT_W          = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  mul_operand_sequencer_if.slave  bus
);

  seq_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b;
  logic             w_accept, w_zero, w_tc;

  logic             r_in_ready, r_out_valid, r_out_timeout, r_mul_start, r_busy;
  logic [WIDTH-1:0] r_out_product, r_mul_data;
  logic             w_in_ready_nxt, w_out_valid_nxt, w_out_timeout_nxt;
  logic             w_mul_start_nxt, w_busy_nxt;
  logic [WIDTH-1:0] w_out_product_nxt, w_mul_data_nxt;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_zero   = (bus.in_a == '0) || (bus.in_b == '0);

  mul_timeout_counter #(
    .CNT_W    (CNT_W),
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state == LOAD_B),
    .i_en  (r_state == WAIT),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_zero ? DONE : START;
      START:   w_state_nxt = LOAD_A;
      LOAD_A:  w_state_nxt = LOAD_B;
      LOAD_B:  w_state_nxt = WAIT;
      WAIT:    if (bus.mul_done || w_tc) w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    w_in_ready_nxt    = (w_state_nxt == IDLE);
    w_out_valid_nxt   = (w_state_nxt == DONE);
    w_mul_start_nxt   = (w_state_nxt == START);
    w_busy_nxt        = (w_state_nxt != IDLE);
    w_mul_data_nxt    = r_mul_data;
    w_out_product_nxt = r_out_product;
    w_out_timeout_nxt = r_out_timeout;
    case (w_state_nxt)
      START, LOAD_A:  w_mul_data_nxt = (r_state == IDLE) ? bus.in_a : r_a;
      LOAD_B, WAIT:   w_mul_data_nxt = r_b;
      default:        w_mul_data_nxt = r_mul_data;
    endcase
    if (r_state == IDLE && w_accept && w_zero) begin
      w_out_product_nxt = '0;
      w_out_timeout_nxt = 1'b0;
    end else if (r_state == WAIT && bus.mul_done) begin
      w_out_product_nxt = bus.mul_product;
      w_out_timeout_nxt = 1'b0;
    end else if (r_state == WAIT && w_tc) begin
      w_out_product_nxt = '0;
      w_out_timeout_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_out_product <= '0;
      r_out_timeout <= 1'b0;
      r_mul_start   <= 1'b0;
      r_mul_data    <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_in_ready    <= w_in_ready_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_product <= w_out_product_nxt;
      r_out_timeout <= w_out_timeout_nxt;
      r_mul_start   <= w_mul_start_nxt;
      r_mul_data    <= w_mul_data_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_accept) begin
      r_a <= bus.in_a;
      r_b <= bus.in_b;
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_product = r_out_product;
  assign bus.out_timeout = r_out_timeout;
  assign bus.mul_start   = r_mul_start;
  assign bus.mul_data    = r_mul_data;
  assign bus.busy        = r_busy;

endmodule

// File: doc/mul_operand_sequencer.md
Name: mul_operand_sequencer

Overview:
Upstream feeder for the repeated-addition multiplier (controller + datapath pair). It accepts operand pairs over a valid/ready stream and serialises A then B onto the multiplier's shared 16-bit data bus with the required start/load timing. It waits for done, then presents the product downstream over a valid/ready stream. It also short-circuits zero operands and flags hung multiplications with a timeout.

Parameters:
WIDTH, 16, operand/product width; must match the multiplier data bus.
TIMEOUT_CYCLES, 65540, maximum cycles allowed in WAIT before aborting; must be at least 2^WIDTH + 4.
CNT_W, 17, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer can accept a pair
in_a  in  WIDTH  operand A (multiplicand)
in_b  in  WIDTH  operand B (repeat count)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_product  out  WIDTH  product, low WIDTH bits
out_timeout  out  1  result aborted by timeout; qualified by out_valid
mul_start  out  1  start pulse to multiplier controller
mul_data  out  WIDTH  multiplier data_in bus
mul_done  in  1  multiplier done
mul_product  in  WIDTH  multiplier product output
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; in_ready=1, out_valid=0, out_product=0, out_timeout=0, mul_start=0, mul_data=0, busy=0. Reset in any state, including mid-WAIT, returns to IDLE and discards the job. Reset does not drive the multiplier; its controller must be reset separately.
- All outputs are registered. in_ready=1 only in IDLE.
- Accept: an input handshake is in_valid & in_ready at a clock edge; it latches A and B into internal registers.
- If the latched A==0 or B==0: next state is DONE with out_product=0 and out_timeout=0. No mul_start is issued, so a zero-operand job takes 1 cycle from accept to out_valid.
- Otherwise the FSM runs these states, one cycle each unless noted:
  - START: mul_start=1, mul_data=A.
  - LOAD_A: mul_start=0, mul_data=A. The controller loads A this cycle.
  - LOAD_B: mul_data=B. The controller loads B and clears P.
  - WAIT: mul_data holds B. The timeout counter clears on entry and increments each cycle.
- Transitions out of WAIT:
  - If mul_done=1: capture mul_product into out_product, set out_timeout=0, go to DONE.
  - Else if counter==TIMEOUT_CYCLES-1: set out_product=0, out_timeout=1, go to DONE.
  - If mul_done and the timeout terminal count coincide, done wins.
- Multiplier contract: mul_done is low by the first WAIT cycle, i.e. within 3 cycles of mul_start. A done level seen in WAIT is treated as completion of the current job.
- DONE: out_valid=1; out_product and out_timeout stay stable while out_valid & !out_ready. On out_valid & out_ready, go to IDLE with out_valid=0. No new job is accepted in the same cycle; minimum 1 IDLE cycle between jobs.
- Arithmetic: the product is mul_product passed through unchanged, i.e. the low WIDTH bits; overflow is not detected. The counter saturates, never wraps.
- Simultaneous in_valid while busy: stalled (in_ready=0), in_a/in_b ignored.

Decomposition:
- Shared package: state encoding constants (IDLE, START, LOAD_A, LOAD_B, WAIT, DONE) and the WIDTH default, so the top-level wrapper and the bench use the same values.
- One natural sub-module: mul_timeout_counter (clear, enable, terminal-count flag, saturating). Everything else stays in the sequencer FSM.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> in_ready=1, out_valid=0, busy=0, mul_start=0, mul_data=0.
- Normal job: A=3, B=5 accepted at T; behavioural multiplier model asserts done after B+1 cycles with product 15 -> mul_start=1 only in T+1; mul_data=3 in T+1..T+2 and 5 from T+3; out_valid with out_product=15, out_timeout=0.
- Zero bypass: A=0, B=9 and then A=7, B=0 -> mul_start never asserted; out_valid at accept+1 with out_product=0, out_timeout=0.
- Back-pressure: result 42 (A=6, B=7) with out_ready=0 for 5 cycles -> out_valid and out_product=42 held stable; in_valid with A=2, B=2 stays stalled (in_ready=0) until the out handshake plus 1 cycle.
- Timeout: TIMEOUT_CYCLES=20 in bench, mul_done held 0 -> out_valid exactly 20 cycles after entering WAIT, out_timeout=1, out_product=0.
- Reset mid-WAIT, plus done/timeout tie: rst asserted in WAIT -> IDLE next cycle with no out_valid. Separately, mul_done=1 on the terminal-count cycle with product 8 -> out_product=8, out_timeout=0.
